// File: rtl/run_monitor_if.sv
// Run-monitor bus: run control and core fetch inputs, run status outputs.
interface run_monitor_if #(
  parameter int unsigned CNT_W = 32
);
  logic             i_start;
  logic             i_sync;
  logic [15:0]      i_addr;
  logic             o_cpu_rst;
  logic             o_dump;
  logic             o_done;
  logic             o_pass;
  logic             o_timeout;
  logic [15:0]      o_trap_pc;
  logic [CNT_W-1:0] o_cycles;
  logic [CNT_W-1:0] o_instrs;

  modport master (
    output i_start, i_sync, i_addr,
    input  o_cpu_rst, o_dump, o_done, o_pass, o_timeout, o_trap_pc, o_cycles, o_instrs
  );

  modport slave (
    input  i_start, i_sync, i_addr,
    output o_cpu_rst, o_dump, o_done, o_pass, o_timeout, o_trap_pc, o_cycles, o_instrs
  );
endinterface

// File: rtl/run_monitor.sv
// Simulation run controller: sequences core reset, detects self-loop traps
// on opcode fetches, ends the run on trap or timeout and pulses a dump.
module run_monitor #(
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned MAX_CYCLES   = 50,
  parameter int unsigned TRAP_REPEAT  = 3,
  parameter logic [15:0] SUCCESS_ADDR = 16'h3469,
  parameter int unsigned CNT_W        = 32,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  run_monitor_if.slave   bus
);

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned TR_W = $clog2(TRAP_REPEAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [RC_W-1:0]  r_rst_cnt;
  logic             r_cpu_rst;
  logic             r_dump;
  logic             r_done;
  logic             r_pass;
  logic             r_timeout;
  logic [15:0]      r_trap_pc;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_instrs;
  logic             r_trk_valid;
  logic [15:0]      r_trk_addr;
  logic [TR_W-1:0]  r_trk_cnt;

  logic [CNT_W-1:0] w_cyc_nxt;
  logic [CNT_W-1:0] w_ins_nxt;
  logic [TR_W-1:0]  w_trk_cnt_nxt;
  logic             w_trap;
  logic             w_tmo;
  logic             w_rst_last;
  logic             w_go;

  // Saturating increments, trap/timeout detection for the current RUN cycle
  always_comb begin
    w_cyc_nxt     = (&r_cycles) ? r_cycles : r_cycles + CNT_W'(1);
    w_ins_nxt     = (&r_instrs) ? r_instrs : r_instrs + CNT_W'(1);
    w_trk_cnt_nxt = TR_W'(1);
    if (r_trk_valid && (bus.i_addr == r_trk_addr)) begin
      w_trk_cnt_nxt = r_trk_cnt + TR_W'(1);
    end
    w_trap     = bus.i_sync && (w_trk_cnt_nxt == TR_W'(TRAP_REPEAT));
    w_tmo      = (MAX_CYCLES != 0) && (w_cyc_nxt == CNT_W'(MAX_CYCLES));
    w_rst_last = (r_rst_cnt == RC_W'(RST_CYCLES - 1));
    w_go       = bus.i_start || (AUTO_START && (r_state == S_IDLE));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_rst_cnt   <= '0;
      r_cpu_rst   <= 1'b1;
      r_dump      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_trap_pc   <= '0;
      r_cycles    <= '0;
      r_instrs    <= '0;
      r_trk_valid <= 1'b0;
      r_trk_addr  <= '0;
      r_trk_cnt   <= '0;
    end else begin
      r_dump <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_go) begin
            r_state     <= S_RESET;
            r_cpu_rst   <= 1'b1;
            r_rst_cnt   <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_trap_pc   <= '0;
            r_cycles    <= '0;
            r_instrs    <= '0;
            r_trk_valid <= 1'b0;
            r_trk_addr  <= '0;
            r_trk_cnt   <= '0;
          end
        end
        S_RESET: begin
          if (w_rst_last) begin
            r_state   <= S_RUN;
            r_cpu_rst <= 1'b0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RC_W'(1);
          end
        end
        S_RUN: begin
          r_cycles <= w_cyc_nxt;
          if (bus.i_sync) begin
            r_instrs    <= w_ins_nxt;
            r_trk_valid <= 1'b1;
            r_trk_addr  <= bus.i_addr;
            r_trk_cnt   <= w_trk_cnt_nxt;
          end
          // A trap on the timeout cycle takes priority
          if (w_trap) begin
            r_trap_pc <= bus.i_addr;
            r_pass    <= (bus.i_addr == SUCCESS_ADDR);
            r_state   <= S_DUMP;
            r_dump    <= 1'b1;
            r_cpu_rst <= 1'b1;
          end else if (w_tmo) begin
            r_timeout <= 1'b1;
            r_state   <= S_DUMP;
            r_dump    <= 1'b1;
            r_cpu_rst <= 1'b1;
          end
        end
        S_DUMP: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_cpu_rst <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_cpu_rst = r_cpu_rst;
  assign bus.o_dump    = r_dump;
  assign bus.o_done    = r_done;
  assign bus.o_pass    = r_pass;
  assign bus.o_timeout = r_timeout;
  assign bus.o_trap_pc = r_trap_pc;
  assign bus.o_cycles  = r_cycles;
  assign bus.o_instrs  = r_instrs;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: reset sequencing, trap/timeout handling,
// abort, manual restart and timeout-disabled runs.
module tb_run_monitor;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  run_monitor_if #(.CNT_W(32)) if_a ();
  run_monitor_if #(.CNT_W(32)) if_b ();
  run_monitor_if #(.CNT_W(32)) if_c ();

  run_monitor #(
    .RST_CYCLES(2), .MAX_CYCLES(50), .TRAP_REPEAT(3),
    .SUCCESS_ADDR(16'h3469), .CNT_W(32), .AUTO_START(1'b1)
  ) u_dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(if_a.slave));

  run_monitor #(
    .RST_CYCLES(2), .MAX_CYCLES(0), .TRAP_REPEAT(3),
    .SUCCESS_ADDR(16'h3469), .CNT_W(32), .AUTO_START(1'b1)
  ) u_dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(if_b.slave));

  run_monitor #(
    .RST_CYCLES(3), .MAX_CYCLES(50), .TRAP_REPEAT(3),
    .SUCCESS_ADDR(16'h3469), .CNT_W(32), .AUTO_START(1'b0)
  ) u_dut_c (.i_clk(clk), .i_rst_n(rst_n), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse reset and advance dut_a to its first RUN cycle
  task automatic restart_a();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic fetch_a(input logic [15:0] addr, input int n);
    for (int k = 0; k < n; k++) begin
      if_a.i_sync = 1'b1;
      if_a.i_addr = addr;
      tick();
    end
    if_a.i_sync = 1'b0;
  endtask

  task automatic fetch_c(input logic [15:0] addr, input int n);
    for (int k = 0; k < n; k++) begin
      if_c.i_sync = 1'b1;
      if_c.i_addr = addr;
      tick();
    end
    if_c.i_sync = 1'b0;
  endtask

  logic [15:0] pass_seq [5];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    if_a.i_start = 1'b0; if_a.i_sync = 1'b0; if_a.i_addr = '0;
    if_b.i_start = 1'b0; if_b.i_sync = 1'b0; if_b.i_addr = '0;
    if_c.i_start = 1'b0; if_c.i_sync = 1'b0; if_c.i_addr = '0;
    pass_seq = '{16'h0200, 16'h0203, 16'h3469, 16'h3469, 16'h3469};

    // Reset values and auto-start sequencing
    #12;
    check("rst_cpu_rst", 32'(if_a.o_cpu_rst), 32'd1);
    check("rst_dump",    32'(if_a.o_dump),    32'd0);
    check("rst_done",    32'(if_a.o_done),    32'd0);
    check("rst_cycles",  if_a.o_cycles,       32'd0);
    check("rst_trap_pc", 32'(if_a.o_trap_pc), 32'd0);
    rst_n = 1'b1;
    tick();
    check("cyc2_cpu_rst", 32'(if_a.o_cpu_rst), 32'd1);
    tick();
    check("cyc3_cpu_rst", 32'(if_a.o_cpu_rst), 32'd1);
    tick();
    check("cyc4_cpu_rst", 32'(if_a.o_cpu_rst), 32'd0);
    check("cyc4_cycles",  if_a.o_cycles,       32'd0);
    check("cyc4_instrs",  if_a.o_instrs,       32'd0);

    // Pass trap
    for (int i = 0; i < 5; i++) begin
      if_a.i_sync = 1'b1;
      if_a.i_addr = pass_seq[i];
      tick();
    end
    if_a.i_sync = 1'b0;
    check("pass_dump",    32'(if_a.o_dump),    32'd1);
    check("pass_cpu_rst", 32'(if_a.o_cpu_rst), 32'd1);
    check("pass_flag",    32'(if_a.o_pass),    32'd1);
    check("pass_pc",      32'(if_a.o_trap_pc), 32'h3469);
    check("pass_instrs",  if_a.o_instrs,       32'd5);
    check("pass_cycles",  if_a.o_cycles,       32'd5);
    check("pass_done_early", 32'(if_a.o_done), 32'd0);
    tick();
    check("pass_dump_end", 32'(if_a.o_dump),   32'd0);
    check("pass_done",     32'(if_a.o_done),   32'd1);
    repeat (2) tick();
    check("pass_done_held", 32'(if_a.o_done),  32'd1);
    check("pass_held",      32'(if_a.o_pass),  32'd1);
    check("pass_cyc_held",  if_a.o_cycles,     32'd5);

    // Fail trap
    restart_a();
    check("fail_start_done", 32'(if_a.o_done), 32'd0);
    fetch_a(16'h0400, 3);
    check("fail_dump",    32'(if_a.o_dump),    32'd1);
    check("fail_pass",    32'(if_a.o_pass),    32'd0);
    check("fail_pc",      32'(if_a.o_trap_pc), 32'h0400);
    check("fail_timeout", 32'(if_a.o_timeout), 32'd0);
    check("fail_instrs",  if_a.o_instrs,       32'd3);

    // Alternating fetches never trap; timeout at 50
    restart_a();
    for (int i = 0; i < 49; i++) begin
      if_a.i_sync = (i < 40);
      if_a.i_addr = (i % 2 == 1) ? 16'h0502 : 16'h0500;
      tick();
    end
    if_a.i_sync = 1'b0;
    check("tmo_pre_dump",    32'(if_a.o_dump),    32'd0);
    check("tmo_pre_cpu_rst", 32'(if_a.o_cpu_rst), 32'd0);
    check("tmo_pre_cycles",  if_a.o_cycles,       32'd49);
    tick();
    check("tmo_dump",    32'(if_a.o_dump),    32'd1);
    check("tmo_flag",    32'(if_a.o_timeout), 32'd1);
    check("tmo_cycles",  if_a.o_cycles,       32'd50);
    check("tmo_pass",    32'(if_a.o_pass),    32'd0);
    check("tmo_pc",      32'(if_a.o_trap_pc), 32'd0);
    check("tmo_instrs",  if_a.o_instrs,       32'd40);

    // Trap completing on RUN cycle 50 beats the timeout
    restart_a();
    for (int i = 0; i < 50; i++) begin
      if_a.i_sync = (i >= 47);
      if_a.i_addr = 16'h0777;
      tick();
    end
    if_a.i_sync = 1'b0;
    check("tie_dump",    32'(if_a.o_dump),    32'd1);
    check("tie_timeout", 32'(if_a.o_timeout), 32'd0);
    check("tie_pc",      32'(if_a.o_trap_pc), 32'h0777);
    check("tie_cycles",  if_a.o_cycles,       32'd50);
    check("tie_instrs",  if_a.o_instrs,       32'd3);

    // Address 0 on a fresh tracker counts from 1; then abort mid-run
    restart_a();
    fetch_a(16'h0000, 2);
    check("zero_no_trap_dump", 32'(if_a.o_dump),    32'd0);
    check("zero_still_run",    32'(if_a.o_cpu_rst), 32'd0);
    repeat (3) tick();
    check("abort_pre_cycles",  if_a.o_cycles,       32'd5);
    rst_n = 1'b0;
    #1;
    check("abort_cpu_rst", 32'(if_a.o_cpu_rst), 32'd1);
    check("abort_cycles",  if_a.o_cycles,       32'd0);
    check("abort_instrs",  if_a.o_instrs,       32'd0);
    rst_n = 1'b1;

    // Manual start: waits in IDLE, two independent runs
    repeat (4) tick();
    check("c_idle_cpu_rst", 32'(if_c.o_cpu_rst), 32'd1);
    check("c_idle_done",    32'(if_c.o_done),    32'd0);
    if_c.i_start = 1'b1;
    tick();
    if_c.i_start = 1'b0;
    repeat (2) tick();
    check("c_reset_cpu_rst", 32'(if_c.o_cpu_rst), 32'd1);
    tick();
    check("c_run_cpu_rst",   32'(if_c.o_cpu_rst), 32'd0);
    fetch_c(16'h3469, 3);
    check("c1_pass", 32'(if_c.o_pass), 32'd1);
    check("c1_dump", 32'(if_c.o_dump), 32'd1);
    repeat (3) tick();
    check("c1_done", 32'(if_c.o_done), 32'd1);
    if_c.i_start = 1'b1;
    tick();
    if_c.i_start = 1'b0;
    check("c2_clr_done",    32'(if_c.o_done),    32'd0);
    check("c2_clr_pass",    32'(if_c.o_pass),    32'd0);
    check("c2_clr_pc",      32'(if_c.o_trap_pc), 32'd0);
    check("c2_clr_cycles",  if_c.o_cycles,       32'd0);
    check("c2_clr_instrs",  if_c.o_instrs,       32'd0);
    check("c2_clr_cpu_rst", 32'(if_c.o_cpu_rst), 32'd1);
    repeat (3) tick();
    check("c2_run_cpu_rst", 32'(if_c.o_cpu_rst), 32'd0);
    fetch_c(16'h0600, 3);
    check("c2_pass",   32'(if_c.o_pass),    32'd0);
    check("c2_pc",     32'(if_c.o_trap_pc), 32'h0600);
    check("c2_instrs", if_c.o_instrs,       32'd3);
    check("c2_cycles", if_c.o_cycles,       32'd3);
    tick();
    check("c2_done",   32'(if_c.o_done),    32'd1);

    // Timeout disabled: stays in RUN for 10000 cycles
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (10000) tick();
    check("b_cpu_rst", 32'(if_b.o_cpu_rst), 32'd0);
    check("b_done",    32'(if_b.o_done),    32'd0);
    check("b_timeout", 32'(if_b.o_timeout), 32'd0);
    check("b_dump",    32'(if_b.o_dump),    32'd0);
    check("b_cycles",  if_b.o_cycles,       32'd9997);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
# run_monitor

Simulation run controller and trap detector for the 6502 core. It sits between the bench clock/reset and `top`. It sequences the core's reset and watches opcode fetches for a self-loop trap (`JMP *`, `Bxx *`), the standard end-of-test idiom. It ends the run on a trap or on a cycle timeout, issues a one-cycle memory-dump pulse, and reports pass/fail. It is the parametrised replacement for fixed-delay reset and dump timing in the CPU bench.

## Interface
- `RST_CYCLES`, 2: cycles `o_cpu_rst` is held high before the run starts (≥1).
- `MAX_CYCLES`, 50: RUN-cycle limit before timeout; 0 disables timeout.
- `TRAP_REPEAT`, 3: consecutive opcode fetches from the same address that declare a trap (≥2).
- `SUCCESS_ADDR`, 16'h3469: trap address that counts as pass.
- `CNT_W`, 32: width of the cycle and instruction counters.
- `AUTO_START`, 1: 1 = leave IDLE on the first clock after reset; 0 = wait for `i_start`.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset. All state is cleared on assertion.
- `i_start`  in  1  level; starts or restarts a run when sampled high in IDLE or DONE.
- `i_sync`  in  1  core opcode-fetch strobe, valid for one cycle per instruction.
- `i_addr`  in  16  core address bus, sampled when `i_sync`=1.
- `o_cpu_rst`  out  1  active-high reset to the core.
- `o_dump`  out  1  one-cycle pulse that triggers the memory dump.
- `o_done`  out  1  run finished; held.
- `o_pass`  out  1  trap detected at `SUCCESS_ADDR`; held.
- `o_timeout`  out  1  run ended by `MAX_CYCLES`; held.
- `o_trap_pc`  out  16  address of the detected trap; 0 if none.
- `o_cycles`  out  CNT_W  RUN cycles elapsed, saturating.
- `o_instrs`  out  CNT_W  `i_sync` pulses during RUN, saturating.

## Operation
- States: IDLE → RESET → RUN → DUMP → DONE.
- Reset values: state IDLE, `o_cpu_rst`=1, all other outputs 0, internal trap tracker cleared.
- IDLE: go to RESET if `AUTO_START`=1 or `i_start`=1.
- RESET: `o_cpu_rst`=1 for exactly `RST_CYCLES` cycles. Entry clears the counters, flags, `o_trap_pc` and the tracker. Then go to RUN.
- RUN: `o_cpu_rst`=0. `o_cycles` increments every cycle. `o_instrs` increments on `i_sync`.
- Trap tracker, on each `i_sync` in RUN:
  - If `i_addr` equals the last fetch address and the tracker is valid: repeat count +1.
  - Otherwise: latch `i_addr`, set repeat count to 1, mark the tracker valid.
  - When the count reaches `TRAP_REPEAT`: latch `o_trap_pc` = `i_addr`, set `o_pass` = (`i_addr`==`SUCCESS_ADDR`), go to DUMP.
- Timeout: when `MAX_CYCLES`≠0 and `o_cycles` reaches `MAX_CYCLES` without a trap, set `o_timeout`=1 and go to DUMP. `o_pass` stays 0.
- Simultaneous trap and timeout in the same cycle: the trap wins and `o_timeout` stays 0.
- DUMP: one cycle, `o_dump`=1, `o_cpu_rst`=1 so the core is frozen. Then go to DONE.
- DONE: `o_done`=1 and `o_cpu_rst`=1. All results are held. `i_start`=1 goes to RESET, which clears the results.
- `o_cpu_rst` is 1 in every state except RUN.
- Counters saturate at all-ones and never wrap.
- `i_sync` outside RUN is ignored.

## Timing
- Registered outputs; no combinational path from input to output.
- After `i_rst_n` deasserts with `AUTO_START`=1: cycle 1 IDLE, cycles 2..(1+`RST_CYCLES`) RESET, RUN from cycle 2+`RST_CYCLES`.
- `o_cpu_rst` falls on the first RUN cycle.
- A trap-completing `i_sync` at edge N gives DUMP (`o_dump`=1) in cycle N+1 and `o_done`=1 from cycle N+2.
- `o_trap_pc` and `o_pass` are valid from the DUMP cycle.
- `o_cycles` equals the number of RUN cycles, including the final one.
- `i_rst_n` low mid-run: `o_cpu_rst`=1 and all other outputs 0 immediately (asynchronous). Deassertion is synchronised by the flop release only.

## Test plan
- Reset and default start: `RST_CYCLES`=2, `AUTO_START`=1 → `o_cpu_rst` high through cycle 3, low from cycle 4, counters 0.
- Pass trap: sync fetches at 0x0200, 0x0203, then 0x3469 three times → `o_dump` pulse one cycle after the third fetch, `o_pass`=1, `o_trap_pc`=0x3469, `o_instrs`=5, `o_done`=1.
- Fail trap: fetches at 0x0400 three times in a row → `o_pass`=0, `o_trap_pc`=0x0400, `o_timeout`=0.
- Non-consecutive repeats: alternating 0x0500/0x0502 fetches for 40 cycles with `MAX_CYCLES`=50 → no trap; `o_timeout`=1 and `o_cycles`=50 at DUMP.
- Tie and disable: third trap fetch lands on RUN cycle 50 → trap wins, `o_timeout`=0. With `MAX_CYCLES`=0 and no trap for 10000 cycles → still in RUN.
- Abort and restart: `i_rst_n` low mid-RUN → outputs reset asynchronously. `AUTO_START`=0 with `i_start` pulsed in DONE → new RESET, counters and flags cleared, second run reports independently.
